// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB encodings and the response-mux state type.
//   HTRANS_* : master transfer types (IDLE/BUSY/NONSEQ/SEQ)
//   HRESP_*  : slave response codes (OKAY/ERROR)
//   state_t  : response-mux data-phase tracker states
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_t;

endpackage

// File: rtl/ahb_resp_mux_if.sv
// ahb_resp_mux_if: bus bundle between the master, two slaves and the mux.
//   sel, htrans                : address-phase select and transfer type
//   hrdata_x/hreadyout_x/hresp_x : per-slave response inputs
//   hrdata/hready/hresp        : muxed response back to master (and slaves)
// Modports:
//   slave  : the response mux's view (consumes select/slave signals)
//   master : the environment's view (drives select/slave signals)
interface ahb_resp_mux_if #(
    parameter int DATA_W = 32
);
    logic              sel;
    logic [1:0]        htrans;
    logic [DATA_W-1:0] hrdata_0;
    logic [DATA_W-1:0] hrdata_1;
    logic              hreadyout_0;
    logic              hreadyout_1;
    logic              hresp_0;
    logic              hresp_1;
    logic [DATA_W-1:0] hrdata;
    logic              hready;
    logic              hresp;

    modport slave (
        input  sel, htrans,
        input  hrdata_0, hrdata_1, hreadyout_0, hreadyout_1, hresp_0, hresp_1,
        output hrdata, hready, hresp
    );

    modport master (
        output sel, htrans,
        output hrdata_0, hrdata_1, hreadyout_0, hreadyout_1, hresp_0, hresp_1,
        input  hrdata, hready, hresp
    );
endinterface

// File: rtl/ahb_wait_timer.sv
// ahb_wait_timer: 8-bit consecutive wait-state counter.
//   clk, rst : clock, async active-high reset
//   inc      : a wait cycle is in progress this cycle
//   clr      : transfer completed (hready=1) this cycle; counter restarts
//   expire   : this wait cycle brings the count to TIMEOUT
module ahb_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic expire
);
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)      cnt_d = '0;
        else if (inc) cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    // Flag on the increment that lands on TIMEOUT so the FSM moves to ERR1
    // on that same edge, giving exactly TIMEOUT wait cycles.
    assign expire = inc && (cnt_q == 8'(TIMEOUT - 1));
endmodule

// File: rtl/ahb_resp_mux.sv
// ahb_resp_mux: AHB slave-response multiplexer for two slaves.
//   hclk, hreset : clock, async active-high reset
//   bus          : ahb_resp_mux_if.slave (select/htrans in, slave
//                  responses in, muxed hrdata/hready/hresp out)
// The address-phase select is captured when a transfer is accepted and
// steers the data-phase response with zero added latency.
// Optional feature: define AHB_RESP_MUX_TIMEOUT_EN to add a wait-state
// watchdog that issues a two-cycle ERROR after TIMEOUT wait cycles.
module ahb_resp_mux
    import ahb_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16   // 2..255
) (
    input  logic           hclk,
    input  logic           hreset,
    ahb_resp_mux_if.slave  bus
);
    state_t state_q, state_d;
    logic   sel_q, sel_d;

    logic              rdy_sel;
    logic              resp_sel;
    logic [DATA_W-1:0] data_sel;

    logic              hready_w;
    logic              hresp_w;
    logic [DATA_W-1:0] hrdata_w;

    logic wait_expire;

    // Only htrans[1] distinguishes active transfers from IDLE/BUSY.
    logic unused_htrans0;
    assign unused_htrans0 = bus.htrans[0];

    assign rdy_sel  = sel_q ? bus.hreadyout_1 : bus.hreadyout_0;
    assign resp_sel = sel_q ? bus.hresp_1     : bus.hresp_0;
    assign data_sel = sel_q ? bus.hrdata_1    : bus.hrdata_0;

`ifdef AHB_RESP_MUX_TIMEOUT_EN
    ahb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk    (hclk),
        .rst    (hreset),
        .inc    ((state_q == ST_DATA) && !rdy_sel),
        .clr    (hready_w),
        .expire (wait_expire)
    );
`else
    localparam int unused_timeout = TIMEOUT;
    assign wait_expire = 1'b0;
`endif

    // Response outputs are combinational from state so the slave's data
    // reaches the master in the same cycle.
    always_comb begin
        hready_w = 1'b1;
        hresp_w  = HRESP_OKAY;
        hrdata_w = '0;
        case (state_q)
            ST_DATA: begin
                hready_w = rdy_sel;
                hresp_w  = resp_sel;
                hrdata_w = data_sel;
            end
`ifdef AHB_RESP_MUX_TIMEOUT_EN
            // Late slave ready is ignored here: the transfer is already
            // being terminated with ERROR.
            ST_ERR1: begin
                hready_w = 1'b0;
                hresp_w  = HRESP_ERROR;
            end
            ST_ERR2: begin
                hresp_w  = HRESP_ERROR;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        if (hready_w) begin
            if (bus.htrans[1]) begin
                state_d = ST_DATA;
                sel_d   = bus.sel;
            end else begin
                state_d = ST_IDLE;
            end
        end
`ifdef AHB_RESP_MUX_TIMEOUT_EN
        // hready is low in both cases, so these never fight the above.
        if (state_q == ST_DATA && wait_expire) state_d = ST_ERR1;
        if (state_q == ST_ERR1)                state_d = ST_ERR2;
`else
        if (wait_expire) state_d = state_q;
`endif
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q <= ST_IDLE;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    assign bus.hready = hready_w;
    assign bus.hresp  = hresp_w;
    assign bus.hrdata = hrdata_w;
endmodule

// File: tb/tb_ahb_resp_mux.sv
// tb_ahb_resp_mux: directed self-checking bench for ahb_resp_mux.
// Inputs change 1 ns after the rising edge; outputs are checked 1 ns later.
// With AHB_RESP_MUX_TIMEOUT_EN defined the watchdog sequence (TIMEOUT=4)
// is exercised as well.
module tb_ahb_resp_mux;
    import ahb_pkg::*;

    logic hclk = 1'b0;
    logic hreset;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_fail = 0;

    ahb_resp_mux_if #(.DATA_W(32)) bus ();

    ahb_resp_mux #(
        .DATA_W  (32),
        .TIMEOUT (4)
    ) dut (
        .hclk   (hclk),
        .hreset (hreset),
        .bus    (bus.slave)
    );

    always #5 hclk = ~hclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic rdy, input logic rsp, input logic [31:0] dat);
        chk({tag, ".hready"}, {31'd0, bus.hready}, {31'd0, rdy});
        chk({tag, ".hresp"},  {31'd0, bus.hresp},  {31'd0, rsp});
        chk({tag, ".hrdata"}, bus.hrdata, dat);
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    initial begin
        hreset          = 1'b1;
        bus.sel         = 1'b0;
        bus.htrans      = HTRANS_IDLE;
        bus.hrdata_0    = 32'hDEAD_0000;
        bus.hrdata_1    = 32'hBEEF_0000;
        bus.hreadyout_0 = 1'b1;
        bus.hreadyout_1 = 1'b1;
        bus.hresp_0     = HRESP_OKAY;
        bus.hresp_1     = HRESP_OKAY;

        // Reset state
        #3;
        chk_out("reset", 1'b1, 1'b0, 32'h0);

        // Single read, accepted on the first edge after reset release
        #4;                         // t=7
        hreset       = 1'b0;
        bus.sel      = 1'b1;
        bus.htrans   = HTRANS_NONSEQ;
        bus.hrdata_1 = 32'hA5A5_0001;
        #1;
        chk_out("idle_pre", 1'b1, 1'b0, 32'h0);
        tick();                     // DATA, slave 1
        bus.htrans = HTRANS_IDLE;
        #1;
        chk_out("single", 1'b1, 1'b0, 32'hA5A5_0001);
        tick();                     // IDLE
        #1;
        chk_out("single_end", 1'b1, 1'b0, 32'h0);

        // Back-to-back NONSEQ to slave 0 then SEQ to slave 1
        bus.sel      = 1'b0;
        bus.htrans   = HTRANS_NONSEQ;
        bus.hrdata_0 = 32'h11;
        bus.hrdata_1 = 32'h22;
        tick();
        bus.sel    = 1'b1;
        bus.htrans = HTRANS_SEQ;
        #1;
        chk_out("b2b_0", 1'b1, 1'b0, 32'h11);
        tick();
        bus.htrans = HTRANS_IDLE;
        #1;
        chk_out("b2b_1", 1'b1, 1'b0, 32'h22);
        tick();

        // Wait states on slave 0 with sel toggling and a pending transfer
        bus.sel         = 1'b0;
        bus.htrans      = HTRANS_NONSEQ;
        bus.hrdata_0    = 32'h33;
        bus.hrdata_1    = 32'h44;
        bus.hreadyout_0 = 1'b0;
        bus.hresp_1     = HRESP_ERROR;
        tick();
        for (int i = 0; i < 3; i++) begin
            bus.sel = ~bus.sel;
            #1;
            chk_out($sformatf("wait%0d", i), 1'b0, 1'b0, 32'h33);
            tick();
        end
        bus.sel         = 1'b1;
        bus.htrans      = HTRANS_IDLE;
        bus.hreadyout_0 = 1'b1;
        #1;
        chk_out("wait_done", 1'b1, 1'b0, 32'h33);
        tick();
        bus.hresp_1 = HRESP_OKAY;

        // Slave 0 two-cycle ERROR passes through unchanged
        bus.sel         = 1'b0;
        bus.htrans      = HTRANS_NONSEQ;
        bus.hreadyout_0 = 1'b0;
        bus.hresp_0     = HRESP_ERROR;
        tick();
        bus.htrans = HTRANS_IDLE;
        #1;
        chk_out("serr1", 1'b0, 1'b1, 32'h33);
        tick();
        bus.hreadyout_0 = 1'b1;
        #1;
        chk_out("serr2", 1'b1, 1'b1, 32'h33);
        tick();
        bus.hresp_0 = HRESP_OKAY;
        #1;
        chk_out("serr_idle", 1'b1, 1'b0, 32'h0);

        // Reset asserted mid-clock during a wait state
        bus.sel         = 1'b1;
        bus.htrans      = HTRANS_NONSEQ;
        bus.hreadyout_1 = 1'b0;
        tick();
        bus.htrans = HTRANS_IDLE;
        #1;
        chk_out("rst_wait", 1'b0, 1'b0, 32'h44);
        #2;
        hreset = 1'b1;
        #1;
        chk_out("rst_mid", 1'b1, 1'b0, 32'h0);
        tick();
        hreset = 1'b0;
        #1;
        chk_out("rst_after", 1'b1, 1'b0, 32'h0);
        tick();
        chk_out("rst_after2", 1'b1, 1'b0, 32'h0);
        bus.hreadyout_1 = 1'b1;

`ifdef AHB_RESP_MUX_TIMEOUT_EN
        // Watchdog: 4 wait cycles, then ERR1, ERR2, IDLE
        bus.sel         = 1'b1;
        bus.htrans      = HTRANS_NONSEQ;
        bus.hreadyout_1 = 1'b0;
        bus.hrdata_1    = 32'h55;
        tick();
        bus.htrans = HTRANS_IDLE;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk_out($sformatf("to_wait%0d", i), 1'b0, 1'b0, 32'h55);
            tick();
        end
        bus.hreadyout_1 = 1'b1;     // late ready must be ignored in ERR1
        #1;
        chk_out("to_err1", 1'b0, 1'b1, 32'h0);
        tick();
        #1;
        chk_out("to_err2", 1'b1, 1'b1, 32'h0);
        tick();
        #1;
        chk_out("to_idle", 1'b1, 1'b0, 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ahb_resp_mux.md
AHB_RESP_MUX -- requirements
Module: ahb_resp_mux

Interface
REQ-001 Parameter DATA_W, default 32: width of read data.
REQ-002 Parameter TIMEOUT, default 16: number of consecutive wait cycles allowed before an ERROR response; legal range 2..255.
REQ-003 hclk  in  1  single clock; all state changes on the rising edge.
REQ-004 hreset  in  1  reset, asynchronous and active-high.
REQ-005 sel  in  1  address-phase slave select, the same signal the address decoder consumes; 0 = slave 0, 1 = slave 1.
REQ-006 htrans  in  2  master transfer type.
REQ-007 hrdata_0 / hrdata_1  in  DATA_W  slave read data.
REQ-008 hreadyout_0 / hreadyout_1  in  1  slave ready.
REQ-009 hresp_0 / hresp_1  in  1  slave response; 0 = OKAY, 1 = ERROR.
REQ-010 hrdata  out  DATA_W  muxed read data to the master.
REQ-011 hready  out  1  muxed ready to the master and to all slaves.
REQ-012 hresp  out  1  muxed response to the master.

Function
REQ-013 An address phase shall be accepted on a rising edge where hready=1 and htrans[1]=1 (NONSEQ or SEQ); on acceptance sel is registered into sel_q and the state becomes DATA.
REQ-014 On a rising edge where hready=1 and htrans is IDLE or BUSY, the state shall become IDLE.
REQ-015 States shall be IDLE, DATA, ERR1 and ERR2.
REQ-016 In IDLE: hready=1, hresp=0, hrdata=0.
REQ-017 In DATA: hrdata, hready and hresp shall equal the sel_q slave's signals combinationally, with zero added latency.
REQ-018 Slave-issued ERROR shall pass through unchanged, including the slave's own two-cycle sequence.
REQ-019 A change of sel during a DATA phase with hready=0 shall not affect sel_q.
REQ-020 Back-to-back transfers: when DATA completes with hready=1 and a new NONSEQ/SEQ is present, sel_q shall update and DATA shall continue with no idle cycle.
REQ-021 Switching slaves between consecutive transfers shall take effect on exactly the edge where the previous data phase completes.

Reset
REQ-022 While hreset=1, regardless of the clock: state=IDLE, sel_q=0 and wait counter=0; outputs are therefore hready=1, hresp=0, hrdata=0.
REQ-023 Reset asserted mid-transfer (DATA, ERR1 or ERR2) shall abandon the transfer immediately with no ERROR issued.
REQ-024 The first address phase can be accepted on the first rising edge after hreset deasserts.

Configuration
REQ-025 Macro AHB_RESP_MUX_TIMEOUT_EN.
REQ-026 When AHB_RESP_MUX_TIMEOUT_EN is defined, an 8-bit wait counter shall increment on each DATA cycle with selected hreadyout=0 and clear whenever hready=1.
REQ-027 When the counter reaches TIMEOUT, the next state shall be ERR1.
REQ-028 ERR1 outputs: hready=0, hresp=1, hrdata=0; the slave's late hreadyout is ignored.
REQ-029 ERR2 outputs: hready=1, hresp=1, hrdata=0; the next state follows REQ-013/REQ-014 (a new address phase may be accepted).
REQ-030 When AHB_RESP_MUX_TIMEOUT_EN is undefined, the counter, ERR1 and ERR2 shall be absent, and DATA shall wait indefinitely for hreadyout.

Structure
REQ-031 Shared package ahb_pkg shall hold the HTRANS encodings (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11), the HRESP encodings (OKAY=0, ERROR=1) and the state enum.
REQ-032 The timeout counter shall be a sub-module ahb_wait_timer, instantiated only under AHB_RESP_MUX_TIMEOUT_EN.

Verification
REQ-033 Reset: assert hreset mid-clock with no edge -> hready=1, hresp=0, hrdata=0 immediately.
REQ-034 Single read: sel=1, htrans=NONSEQ, hreadyout_1=1, hrdata_1=0xA5A5_0001 -> hrdata=0xA5A5_0001, hresp=0 in the following cycle.
REQ-035 Back-to-back: NONSEQ to sel=0 (data 0x11), then SEQ to sel=1 (data 0x22) -> hrdata 0x11 then 0x22 on consecutive cycles, hready=1 throughout.
REQ-036 Wait states: hreadyout_0 low for 3 cycles, with sel toggled during the waits -> hready=0 for 3 cycles; data still taken from slave 0.
REQ-037 Timeout (macro on, TIMEOUT=4): hreadyout_1 held 0 -> 4 wait cycles, then ERR1 (hready=0, hresp=1), then ERR2 (hready=1, hresp=1), then IDLE.
REQ-038 Reset mid-wait: hreset pulse in DATA with hreadyout=0 -> IDLE outputs; no hresp=1 is ever driven.
